// File: rtl/fp_unpack_pipe.sv
// Operand unpacker for the FP adder front end: field split, classification,
// magnitude ordering and exponent difference behind a registered skid buffer.
module fp_unpack_pipe #(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MAN_W   = 23,
  parameter bit          SWAP_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sign_a,
  output logic                 sign_b,
  output logic [EXP_W-1:0]     exp_a,
  output logic [EXP_W-1:0]     exp_b,
  output logic [MAN_W:0]       mant_a,
  output logic [MAN_W:0]       mant_b,
  output logic [2:0]           class_a,
  output logic [2:0]           class_b,
  output logic                 swapped,
  output logic [EXP_W-1:0]     exp_diff
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned MW = MAN_W + 1;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_NAN  = 3'd4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MW-1:0]    mant;
    logic [2:0]       cls;
  } op_t;

  typedef struct packed {
    logic             sign_a;
    logic             sign_b;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [MW-1:0]    mant_a;
    logic [MW-1:0]    mant_b;
    logic [2:0]       class_a;
    logic [2:0]       class_b;
    logic             swapped;
    logic [EXP_W-1:0] exp_diff;
  } res_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  function automatic logic [2:0] classify(input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] m);
    if (e == '0) return (m == '0) ? CLS_ZERO : CLS_SUB;
    if (e == '1) return (m == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  // Zero/subnormal share the minimum effective exponent and carry no hidden bit.
  function automatic op_t unpack_op(input logic [W-1:0] x);
    op_t o;
    o.sign = x[W-1];
    o.cls  = classify(x[W-2:MAN_W], x[MAN_W-1:0]);
    o.exp  = (o.cls == CLS_ZERO || o.cls == CLS_SUB) ? EXP_W'(1) : x[W-2:MAN_W];
    o.mant = {(o.cls >= CLS_NORM), x[MAN_W-1:0]};
    return o;
  endfunction

  state_t state_q;
  res_t   main_q;
  res_t   skid_q;
  logic   in_ready_q;
  logic   out_valid_q;

  logic   swap;
  op_t    op_hi;
  op_t    op_lo;
  res_t   unpk;
  logic   acc;
  logic   take;

  // Sign bit is excluded from the magnitude compare; ties keep input order.
  always_comb begin
    swap  = 1'b0;
    unpk  = '0;
    if (SWAP_EN) swap = (b[W-2:0] > a[W-2:0]);
    op_hi = unpack_op(swap ? b : a);
    op_lo = unpack_op(swap ? a : b);
    unpk.sign_a   = op_hi.sign;
    unpk.sign_b   = op_lo.sign;
    unpk.exp_a    = op_hi.exp;
    unpk.exp_b    = op_lo.exp;
    unpk.mant_a   = op_hi.mant;
    unpk.mant_b   = op_lo.mant;
    unpk.class_a  = op_hi.cls;
    unpk.class_b  = op_lo.cls;
    unpk.swapped  = swap;
    unpk.exp_diff = op_hi.exp - op_lo.exp;
  end

  assign acc  = in_valid && in_ready_q;
  assign take = out_valid_q && out_ready;

  // Skid buffer control: main register feeds the outputs, skid absorbs one stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= acc;
          if (acc) begin
            main_q  <= unpk;
            state_q <= S_ONE;
          end
        end
        S_ONE: begin
          if (acc && take) begin
            main_q <= unpk;
          end else if (acc) begin
            skid_q     <= unpk;
            state_q    <= S_FULL;
            in_ready_q <= 1'b0;
          end else if (take) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        S_FULL: begin
          if (take) begin
            main_q     <= skid_q;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sign_a    = main_q.sign_a;
  assign sign_b    = main_q.sign_b;
  assign exp_a     = main_q.exp_a;
  assign exp_b     = main_q.exp_b;
  assign mant_a    = main_q.mant_a;
  assign mant_b    = main_q.mant_b;
  assign class_a   = main_q.class_a;
  assign class_b   = main_q.class_b;
  assign swapped   = main_q.swapped;
  assign exp_diff  = main_q.exp_diff;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Directed/random bench for fp_unpack_pipe with a FIFO scoreboard of expected results.
module tb_fp_unpack_pipe;

  logic        clk;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b;
  logic        sign_a, sign_b, swapped;
  logic [7:0]  exp_a, exp_b, exp_diff;
  logic [23:0] mant_a, mant_b;
  logic [2:0]  class_a, class_b;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [31:0] a1, b1;
  logic        sign_a1, sign_b1, swapped1;
  logic [7:0]  exp_a1, exp_b1, exp_diff1;
  logic [23:0] mant_a1, mant_b1;
  logic [2:0]  class_a1, class_b1;

  logic [80:0] obs0, obs1;
  logic [80:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;

  fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .SWAP_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
    .mant_a(mant_a), .mant_b(mant_b), .class_a(class_a), .class_b(class_b),
    .swapped(swapped), .exp_diff(exp_diff)
  );

  fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .SWAP_EN(1'b0)) u_noswap (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sign_a(sign_a1), .sign_b(sign_b1), .exp_a(exp_a1), .exp_b(exp_b1),
    .mant_a(mant_a1), .mant_b(mant_b1), .class_a(class_a1), .class_b(class_b1),
    .swapped(swapped1), .exp_diff(exp_diff1)
  );

  assign obs0 = {sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, class_a, class_b, swapped, exp_diff};
  assign obs1 = {sign_a1, sign_b1, exp_a1, exp_b1, mant_a1, mant_b1, class_a1, class_b1, swapped1, exp_diff1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [80:0] lit(input logic sa, input logic sb, input logic [7:0] ea,
                                      input logic [7:0] eb, input logic [23:0] ma,
                                      input logic [23:0] mb, input logic [2:0] ca,
                                      input logic [2:0] cb, input logic sw, input logic [7:0] d);
    return {sa, sb, ea, eb, ma, mb, ca, cb, sw, d};
  endfunction

  function automatic void field(input logic [31:0] v, output logic [7:0] e,
                                output logic [23:0] m, output logic [2:0] c);
    logic [7:0]  raw;
    logic [22:0] f;
    raw = v[30:23];
    f   = v[22:0];
    if (raw == 8'd0) begin
      c = (f == 23'd0) ? 3'd0 : 3'd1;
      e = 8'd1;
      m = {1'b0, f};
    end else if (raw == 8'hFF) begin
      c = (f == 23'd0) ? 3'd3 : 3'd4;
      e = 8'hFF;
      m = {1'b1, f};
    end else begin
      c = 3'd2;
      e = raw;
      m = {1'b1, f};
    end
  endfunction

  function automatic logic [80:0] model(input logic [31:0] x, input logic [31:0] y, input bit swap_en);
    logic [31:0] hi, lo;
    logic [7:0]  eh, el;
    logic [23:0] mh, ml;
    logic [2:0]  ch, cl;
    logic        sw;
    sw = swap_en && (y[30:0] > x[30:0]);
    hi = sw ? y : x;
    lo = sw ? x : y;
    field(hi, eh, mh, ch);
    field(lo, el, ml, cl);
    return {hi[31], lo[31], eh, el, mh, ml, ch, cl, sw, 8'(eh - el)};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 4))
      0: x[30:23] = 8'h00;
      1: x[30:23] = 8'hFF;
      2: x[22:0]  = 23'd0;
      default: ;
    endcase
    return x;
  endfunction

  task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb);
    bit acc = 1'b0;
    a = xa;
    b = xb;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("send_accept", 81'(acc), 81'(1));
  endtask

  task automatic send1(input logic [31:0] xa, input logic [31:0] xb);
    bit acc = 1'b0;
    a1 = xa;
    b1 = xb;
    in_valid1 = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready1;
      step();
    end
    in_valid1 = 1'b0;
    chk("send1_accept", 81'(acc), 81'(1));
  endtask

  // Scoreboard: pop-and-compare on every output take, push on every accept.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          n_out++;
          checks++;
          assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL sb_unexpected_output: observed %h expected none", obs0);
          end
          if (sb_q.size() > 0) chk("sb_data", obs0, sb_q.pop_front());
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(model(a, b, 1'b1));
      end
    end
  endtask

  initial begin
    logic [31:0] pa[4];
    logic [31:0] pb[4];
    int          k;
    int          n0;
    bit          acc;

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
    fork monitor(); join_none

    step();
    step();
    chk("rst_in_ready", 81'(in_ready), 81'(0));
    chk("rst_out_valid", 81'(out_valid), 81'(0));
    chk("rst_data", obs0, 81'(0));
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", 81'(in_ready), 81'(1));
    chk("post_rst_out_valid", 81'(out_valid), 81'(0));

    // Directed classification / ordering cases
    out_ready = 1'b1;
    send(32'h3F800000, 32'h40000000);
    chk("t1_valid", 81'(out_valid), 81'(1));
    chk("t1_data", obs0, lit(0, 0, 8'h80, 8'h7F, 24'h800000, 24'h800000, 3'd2, 3'd2, 1, 8'd1));
    step();
    chk("t1_drained", 81'(out_valid), 81'(0));

    send(32'h00000001, 32'h80000000);
    chk("t2_data", obs0, lit(0, 1, 8'h01, 8'h01, 24'h000001, 24'h000000, 3'd1, 3'd0, 0, 8'd0));
    send(32'h7F800000, 32'h7FC00000);
    chk("t3_data", obs0, lit(0, 0, 8'hFF, 8'hFF, 24'hC00000, 24'h800000, 3'd4, 3'd3, 1, 8'd0));
    send(32'h3F800000, 32'hBF800000);
    chk("t4_equal_mag", obs0, lit(0, 1, 8'h7F, 8'h7F, 24'h800000, 24'h800000, 3'd2, 3'd2, 0, 8'd0));
    step();

    // Backpressure: four pairs offered against a stalled consumer
    for (int i = 0; i < 4; i++) begin
      pa[i] = rnd_op();
      pb[i] = rnd_op();
    end
    out_ready = 1'b0;
    k = 0;
    a = pa[0]; b = pb[0]; in_valid = 1'b1;
    repeat (4) begin
      acc = in_ready;
      step();
      if (acc) begin
        k++;
        a = pa[k]; b = pb[k];
      end
    end
    chk("bp_accepted", 81'(k), 81'(2));
    chk("bp_in_ready", 81'(in_ready), 81'(0));
    chk("bp_out_valid", 81'(out_valid), 81'(1));
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("bp_no_gap", 81'(out_valid), 81'(1));
      acc = in_ready && in_valid;
      step();
      if (acc) begin
        k++;
        if (k < 4) begin
          a = pa[k]; b = pb[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("bp_all_accepted", 81'(k), 81'(4));
    chk("bp_drained", 81'(out_valid), 81'(0));

    // Streaming at full rate
    n0 = n_out;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = rnd_op();
      b = (i % 5 == 0) ? {~a[31], a[30:0]} : rnd_op();
      if (i > 0) chk("stream_valid", 81'(out_valid), 81'(1));
      chk("stream_ready", 81'(in_ready), 81'(1));
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("stream_count", 81'(n_out - n0), 81'(16));

    // Reset while FULL
    out_ready = 1'b0;
    send(rnd_op(), rnd_op());
    send(rnd_op(), rnd_op());
    chk("full_in_ready", 81'(in_ready), 81'(0));
    reset = 1'b1;
    a = rnd_op(); b = rnd_op(); in_valid = 1'b1;
    step();
    sb_q.delete();
    in_valid = 1'b0;
    chk("rstfull_out_valid", 81'(out_valid), 81'(0));
    chk("rstfull_in_ready", 81'(in_ready), 81'(0));
    chk("rstfull_data", obs0, 81'(0));
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rstfull_ready_back", 81'(in_ready), 81'(1));
    chk("rstfull_no_stale", 81'(out_valid), 81'(0));
    step();
    step();
    chk("rstfull_still_empty", 81'(out_valid), 81'(0));

    // Pass-through ordering with wrapping exponent difference
    send1(32'h3F800000, 32'h40000000);
    chk("ns1_valid", 81'(out_valid1), 81'(1));
    chk("ns1_data", obs1, lit(0, 0, 8'h7F, 8'h80, 24'h800000, 24'h800000, 3'd2, 3'd2, 0, 8'hFF));
    send1(32'h80000000, 32'h7F800000);
    chk("ns2_data", obs1, lit(1, 0, 8'h01, 8'hFF, 24'h000000, 24'h800000, 3'd0, 3'd3, 0, 8'h02));
    step();
    chk("ns_drained", 81'(out_valid1), 81'(0));

    chk("sb_empty", 81'(sb_q.size()), 81'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_unpack_pipe.md
# fp_unpack_pipe

Parametrised, pipelined operand unpacker at the front of the floating-point adder datapath. It accepts a pair of packed IEEE-754-style operands and splits each into sign, exponent and mantissa fields, adding the hidden bit. It classifies each operand, orders the pair so the larger magnitude comes out first, and computes the exponent difference for the alignment stage. Flow control is a valid/ready handshake with a registered two-entry skid buffer, so it can sit between stages with independent stall behaviour.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa field width; W = 1+EXP_W+MAN_W is the packed operand width
- SWAP_EN, 1, 1 = order operands by magnitude; 0 = pass A/B in input order
- clk  in  1  clock; the block uses this single clock only
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair on a/b is valid
- in_ready  out  1  block can accept a pair (registered)
- a, b  in  W  packed operands: sign at [W-1], exponent at [W-2:MAN_W], mantissa at [MAN_W-1:0]
- out_valid  out  1  output fields valid
- out_ready  in  1  downstream accepts output
- sign_a, sign_b  out  1  signs of the (possibly swapped) operands
- exp_a, exp_b  out  EXP_W  effective exponents (see Operation)
- mant_a, mant_b  out  MAN_W+1  mantissa with hidden bit at MSB
- class_a, class_b  out  3  0=ZERO, 1=SUB, 2=NORM, 3=INF, 4=NAN
- swapped  out  1  1 = output A came from input b
- exp_diff  out  EXP_W  exp_a − exp_b, always ≥ 0 when SWAP_EN=1

## Operation
- A transfer occurs on any edge where valid && ready. Outputs are a pure function of the accepted a/b. There are no other side effects.
- Classification, per operand:
  - exp==0 && man==0 → ZERO
  - exp==0 && man!=0 → SUB
  - exp==all-ones && man==0 → INF
  - exp==all-ones && man!=0 → NAN
  - otherwise NORM
- Hidden bit: 1 for NORM, INF and NAN; 0 for ZERO and SUB.
- Effective exponent: 1 for SUB and ZERO; the raw field otherwise.
- Swap: when SWAP_EN=1, swap if b[W-2:0] > a[W-2:0] as unsigned. Equal magnitudes do not swap. The sign bit is excluded from the compare. When SWAP_EN=0, swapped=0 always.
- exp_diff: computed modulo 2^EXP_W. With SWAP_EN=1 it never wraps.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1
  - ONE: main register holds data, out_valid=1, in_ready=1
  - FULL: main register and skid register hold data, out_valid=1, in_ready=0
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on output take with no accept.
  - ONE stays ONE on simultaneous accept and take (main register reloaded).
  - ONE→FULL on accept without take (new data goes to skid).
  - FULL→ONE on take (skid moves to main).
- Order is strictly FIFO. No pair is dropped or duplicated.
- Reset has priority over every event:
  - State goes to EMPTY and the contents are discarded.
  - A transfer offered in the reset cycle is ignored.

## Timing
- Latency: 1 cycle. A pair accepted at edge N is presented with out_valid=1 after edge N when the block was EMPTY, or when it was ONE with a simultaneous take.
- Throughput: 1 pair per cycle while out_ready=1.
- in_ready and out_valid are driven directly from flops. There is no combinational path from in_valid or out_ready to any output.
- Data outputs are flop outputs and hold stable while out_valid=1 && out_ready=0.
- Reset values:
  - out_valid=0; all data outputs 0; swapped=0; exp_diff=0; class fields 0.
  - in_ready=0 while reset is asserted, 1 from the first edge after reset deasserts.
- Clearing FULL: in_ready returns to 1 on the edge following the take that clears FULL.

## Test plan
- EXP_W=8, MAN_W=23, SWAP_EN=1; a=0x3F800000, b=0x40000000 → swapped=1, exp_a=0x80, exp_b=0x7F, mant_a=0x800000, mant_b=0x800000, exp_diff=1, class both NORM, out_valid one cycle after accept.
- a=0x00000001, b=0x80000000 → class_a=SUB, exp_a=1, mant_a=0x000001; class_b=ZERO, sign_b=1, exp_b=1, mant_b=0; swapped=0, exp_diff=0.
- a=0x7F800000, b=0x7FC00000 → swapped=1, class_a=NAN, mant_a=0xC00000, class_b=INF, exp_diff=0. Equal-magnitude pair a=0x3F800000, b=0xBF800000 → swapped=0.
- Backpressure: out_ready=0 while 4 back-to-back pairs are offered → exactly 2 accepted and in_ready=0 after the 2nd. Then out_ready=1 → all 4 emerge in order, with no gaps after the stall releases.
- Streaming: in_valid=out_ready=1 for 16 random pairs → 16 outputs at 1/cycle, each matching the reference model.
- Reset in FULL state → out_valid=0 and in_ready=0 on the following edge, in_ready=1 one edge after reset drops, no stale pair emitted. Repeat with SWAP_EN=0 and a<b → swapped=0, and exp_diff wraps modulo 256.
